// File: rtl/motor_pkg.sv
// Shared types for the multi-channel motor PWM driver: command modes,
// per-channel FSM states and default parameter values.
package motor_pkg;

    typedef enum logic [1:0] {
        MODE_STOP  = 2'b00,
        MODE_FWD   = 2'b01,
        MODE_REV   = 2'b10,
        MODE_BRAKE = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_REVERSE,
        ST_BRK
    } ch_state_t;

    localparam int DEF_NUM_CH    = 2;
    localparam int DEF_CNT_W     = 8;
    localparam int DEF_RAMP_STEP = 4;
    localparam int DEF_RAMP_DIV  = 4;

    // FWD/REV carry a duty target; STOP/BRAKE do not.
    function automatic logic is_drive(input mode_t m);
        return (m == MODE_FWD) || (m == MODE_REV);
    endfunction

endpackage

// File: rtl/motor_pwm_channel.sv
// One H-bridge channel: mode/target registers, STOP/RUN/REVERSE/BRK FSM,
// ramped duty and registered pwm/dir/brake outputs.
// MOTOR_RAMP_EN defined: duty steps by RAMP_STEP on each tick.
// Undefined: duty follows the effective target one cycle later.
module motor_pwm_channel
    import motor_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
`ifdef MOTOR_RAMP_EN
    ,
    parameter int RAMP_STEP = DEF_RAMP_STEP
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] cnt,
`ifdef MOTOR_RAMP_EN
    input  logic             tick,
`endif
    input  logic             cmd_stb,
    input  mode_t            cmd_mode,
    input  logic [CNT_W-1:0] cmd_duty,
    output logic             pwm,
    output logic             dir,
    output logic             brake
);

`ifdef MOTOR_RAMP_EN
    localparam logic [CNT_W:0]   STEP_W = (CNT_W+1)'(RAMP_STEP);
    localparam logic [CNT_W-1:0] STEP_N = CNT_W'(RAMP_STEP);

    // One ramp step toward eff, done one bit wider so nothing wraps;
    // lands exactly on eff instead of overshooting.
    function automatic logic [CNT_W-1:0] ramp_step(input logic [CNT_W-1:0] cur,
                                                   input logic [CNT_W-1:0] eff);
        logic [CNT_W:0] cur_w, eff_w, up_w, lim_w;
        cur_w = {1'b0, cur};
        eff_w = {1'b0, eff};
        up_w  = cur_w + STEP_W;
        lim_w = eff_w + STEP_W;
        if (cur_w < eff_w)
            return (up_w > eff_w) ? eff : up_w[CNT_W-1:0];
        else if (cur_w > eff_w)
            return (cur_w > lim_w) ? (cur - STEP_N) : eff;
        else
            return cur;
    endfunction
`endif

    ch_state_t        state_q, state_d;
    mode_t            mode_q, mode_d, mode_n;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic [CNT_W-1:0] eff_target;
    logic             dir_q, dir_d;
    logic             pwm_q, pwm_d;
    logic             brake_q, brake_d;
    logic             want_fwd;

    // Command capture, FSM next state, duty update and output decode.
    always_comb begin
        mode_n   = cmd_stb ? cmd_mode : mode_q;
        mode_d   = mode_n;
        target_d = target_q;
        if (cmd_stb)
            target_d = is_drive(cmd_mode) ? cmd_duty : '0;
        want_fwd = (mode_n == MODE_FWD);
        state_d  = state_q;
        dir_d    = dir_q;

        case (state_q)
            ST_IDLE: begin
                // duty is 0 here, so dir may change freely
                if (mode_n == MODE_BRAKE) begin
                    state_d = ST_BRK;
                end else if (is_drive(mode_n)) begin
                    state_d = ST_RUN;
                    dir_d   = want_fwd;
                end
            end
            ST_RUN: begin
                if (mode_n == MODE_BRAKE)
                    state_d = ST_BRK;
                else if (is_drive(mode_n) && (want_fwd != dir_q))
                    state_d = ST_REVERSE;
                else if ((mode_n == MODE_STOP) && (duty_q == '0))
                    state_d = ST_IDLE;
            end
            ST_REVERSE: begin
                // ramp down on the old dir; flip only once fully unloaded
                if (mode_n == MODE_BRAKE) begin
                    state_d = ST_BRK;
                end else if (!is_drive(mode_n) || (want_fwd == dir_q)) begin
                    state_d = ST_RUN;
                end else if (duty_q == '0) begin
                    state_d = ST_RUN;
                    dir_d   = ~dir_q;
                end
            end
            ST_BRK: begin
                if (is_drive(mode_n)) begin
                    state_d = ST_RUN;
                    dir_d   = want_fwd;
                end else if (mode_n == MODE_STOP) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Built from registered state only: a command landing with a tick
        // takes effect from the following tick.
        eff_target = ((state_q == ST_RUN) && is_drive(mode_q)) ? target_q : '0;

`ifdef MOTOR_RAMP_EN
        duty_d = tick ? ramp_step(duty_q, eff_target) : duty_q;
`else
        duty_d = eff_target;
`endif
        if (state_d == ST_BRK)
            duty_d = '0;

        pwm_d   = (state_d != ST_BRK) && (cnt < duty_q);
        brake_d = (state_d == ST_BRK);
    end

    // Channel state and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_STOP;
            target_q <= '0;
            duty_q   <= '0;
            dir_q    <= 1'b1;
            pwm_q    <= 1'b0;
            brake_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            target_q <= target_d;
            duty_q   <= duty_d;
            dir_q    <= dir_d;
            pwm_q    <= pwm_d;
            brake_q  <= brake_d;
        end
    end

    assign pwm   = pwm_q;
    assign dir   = dir_q;
    assign brake = brake_q;

endmodule

// File: rtl/motor_pwm_array.sv
// NUM_CH-channel motor PWM driver: shared period counter, ramp prescaler,
// command decode and cmd_err; one motor_pwm_channel per channel.
// MOTOR_RAMP_EN defined: soft-start/stop ramping with a RAMP_DIV prescaler.
// Undefined: duty jumps to target, no prescaler.
module motor_pwm_array
    import motor_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int RAMP_STEP = DEF_RAMP_STEP,
    parameter int RAMP_DIV  = DEF_RAMP_DIV
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [$clog2(NUM_CH):0]   cmd_ch,
    input  mode_t                     cmd_mode,
    input  logic [CNT_W-1:0]          cmd_duty,
    output logic                      cmd_err,
    output logic [NUM_CH-1:0]         pwm,
    output logic [NUM_CH-1:0]         dir,
    output logic [NUM_CH-1:0]         brake
);

    localparam int               CH_W     = $clog2(NUM_CH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wrap;
    logic              cmd_ready_q, cmd_err_q, cmd_err_d;
    logic              accept, ch_ok;
    logic [NUM_CH-1:0] ch_stb;

`ifdef MOTOR_RAMP_EN
    localparam int PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             pre_last, tick;

    // Prescaler advances once per PWM period; tick on its last count.
    always_comb begin
        pre_last = (pre_q == PRE_W'(RAMP_DIV - 1));
        pre_d    = pre_q;
        if (wrap)
            pre_d = pre_last ? '0 : pre_q + 1'b1;
        tick = wrap && pre_last;
    end

    // Prescaler register.
    always_ff @(posedge clk) begin
        if (reset) pre_q <= '0;
        else       pre_q <= pre_d;
    end
`else
    // Ramp parameters are only meaningful with ramping built in.
    if (RAMP_STEP < 1 || RAMP_DIV < 1) begin : g_ramp_params_unused
    end
`endif

    // Period counter 0..2**CNT_W-2, command decode and error flag.
    always_comb begin
        wrap      = (cnt_q == CNT_LAST);
        cnt_d     = wrap ? '0 : cnt_q + 1'b1;
        accept    = cmd_valid && cmd_ready_q;
        ch_ok     = (cmd_ch < CH_W'(NUM_CH));
        cmd_err_d = accept && !ch_ok;
        ch_stb    = '0;
        for (int i = 0; i < NUM_CH; i++)
            ch_stb[i] = accept && ch_ok && (cmd_ch == CH_W'(i));
    end

    // Counter and handshake registers; ready rises the cycle after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            cmd_ready_q <= 1'b1;
            cmd_err_q   <= cmd_err_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign cmd_err   = cmd_err_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        motor_pwm_channel #(
            .CNT_W     (CNT_W)
`ifdef MOTOR_RAMP_EN
            ,
            .RAMP_STEP (RAMP_STEP)
`endif
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .cnt      (cnt_q),
`ifdef MOTOR_RAMP_EN
            .tick     (tick),
`endif
            .cmd_stb  (ch_stb[g]),
            .cmd_mode (cmd_mode),
            .cmd_duty (cmd_duty),
            .pwm      (pwm[g]),
            .dir      (dir[g]),
            .brake    (brake[g])
        );
    end

endmodule

// File: tb/tb_motor_pwm_array.sv
// Bench for motor_pwm_array (CNT_W=4, period 15, RAMP_STEP=4, RAMP_DIV=1).
// Expectations follow MOTOR_RAMP_EN the same way the design does.
module tb_motor_pwm_array;
    import motor_pkg::*;

`ifdef MOTOR_RAMP_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_ch;
    mode_t      cmd_mode;
    logic [3:0] cmd_duty;
    logic       cmd_err;
    logic [1:0] pwm, dir, brake;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         ch;
        mode_t      mode;
        int         duty;
        int         hi0;
        int         hi1;
        logic [1:0] dir;
        logic [1:0] brk;
    } vec_t;

    vec_t tbl[10];
    vec_t sb[$];

    motor_pwm_array #(.NUM_CH(2), .CNT_W(4), .RAMP_STEP(4), .RAMP_DIV(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_ch    (cmd_ch),
        .cmd_mode  (cmd_mode),
        .cmd_duty  (cmd_duty),
        .cmd_err   (cmd_err),
        .pwm       (pwm),
        .dir       (dir),
        .brake     (brake)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input int ch, input mode_t m, input int d);
        cmd_valid = 1'b1;
        cmd_ch    = 2'(ch);
        cmd_mode  = m;
        cmd_duty  = 4'(d);
        chk("cmd_ready", int'(cmd_ready), 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic win2(output int h0, output int h1);
        h0 = 0;
        h1 = 0;
        repeat (15) begin
            h0 += int'(pwm[0]);
            h1 += int'(pwm[1]);
            @(negedge clk);
        end
    endtask

    task automatic win(input int ch, output int h);
        h = 0;
        repeat (15) begin
            h += int'(pwm[ch]);
            @(negedge clk);
        end
    endtask

    task automatic wait_rise(input int ch);
        bit ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (pwm[ch]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("pwm_rise_timeout", int'(ok), 1);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin : main
        int   h0, h1, n, lo, hi;
        int   exp_w[3];
        vec_t e;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_ch    = '0;
        cmd_mode  = MODE_STOP;
        cmd_duty  = '0;

        // Reset held 5 cycles
        repeat (5) @(negedge clk);
        chk("rst_pwm",   int'(pwm),       0);
        chk("rst_brake", int'(brake),     0);
        chk("rst_dir",   int'(dir),       3);
        chk("rst_ready", int'(cmd_ready), 0);
        chk("rst_err",   int'(cmd_err),   0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", int'(cmd_ready), 1);

        // Ramp up ch0 to 10: per-period high counts
        send(0, MODE_FWD, 10);
        wait_rise(0);
        exp_w[0] = RAMP ? 4 : 10;
        exp_w[1] = RAMP ? 8 : 10;
        exp_w[2] = 10;
        for (int k = 0; k < 3; k++) begin
            win(0, h0);
            chk($sformatf("ramp_up_p%0d", k), h0, exp_w[k]);
        end

        // Reversal: ch0 at 8, REV 12; dir flips only with pwm off
        do_reset();
        send(0, MODE_FWD, 8);
        repeat (100) @(negedge clk);
        send(0, MODE_REV, 12);
        n = 0;
        while (dir[0] && n < 300) begin
            @(negedge clk);
            n++;
        end
        lo = RAMP ? 16 : 2;
        hi = RAMP ? 31 : 2;
        total++;
        if (n < lo || n > hi) begin
            bad++;
            $display("FAIL rev_delay: got %0d expected %0d..%0d", n, lo, hi);
        end
        chk("rev_pwm_at_flip", int'(pwm[0]), 0);
        wait_rise(0);
        exp_w[0] = RAMP ? 4 : 12;
        exp_w[1] = RAMP ? 8 : 12;
        exp_w[2] = 12;
        for (int k = 0; k < 3; k++) begin
            win(0, h0);
            chk($sformatf("rev_up_p%0d", k), h0, exp_w[k]);
        end
        chk("rev_dir_after", int'(dir[0]), 0);

        // Brake / boundaries on ch1
        do_reset();
        send(1, MODE_FWD, 15);
        repeat (100) @(negedge clk);
        win(1, h1);
        chk("full_duty", h1, 15);
        send(1, MODE_BRAKE, 0);
        chk("brk_pwm",   int'(pwm[1]),   0);
        chk("brk_brake", int'(brake[1]), 1);
        send(1, MODE_FWD, 0);
        chk("unbrk_brake", int'(brake[1]), 0);
        win(1, h1);
        chk("zero_duty", h1, 0);

        // Bad channel pulses cmd_err for exactly one cycle
        send(2, MODE_FWD, 7);
        chk("err_pulse", int'(cmd_err), 1);
        @(negedge clk);
        chk("err_clear", int'(cmd_err), 0);

        // Back-to-back commands to ch0: the last one wins
        cmd_valid = 1'b1;
        cmd_ch    = 2'd0;
        cmd_mode  = MODE_FWD;
        cmd_duty  = 4'd3;
        @(posedge clk);
        @(negedge clk);
        cmd_duty  = 4'd9;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (100) @(negedge clk);
        win(0, h0);
        chk("b2b_last_wins", h0, 9);

        // Table: steady-state results after each command
        do_reset();
        tbl[0] = '{0, MODE_FWD,   10, 10,  0, 2'b11, 2'b00};
        tbl[1] = '{1, MODE_REV,    6, 10,  6, 2'b01, 2'b00};
        tbl[2] = '{0, MODE_REV,   12, 12,  6, 2'b00, 2'b00};
        tbl[3] = '{1, MODE_BRAKE,  0, 12,  0, 2'b00, 2'b10};
        tbl[4] = '{1, MODE_FWD,   15, 12, 15, 2'b10, 2'b00};
        tbl[5] = '{0, MODE_STOP,   0,  0, 15, 2'b10, 2'b00};
        tbl[6] = '{0, MODE_FWD,    0,  0, 15, 2'b11, 2'b00};
        tbl[7] = '{2, MODE_FWD,    7,  0, 15, 2'b11, 2'b00};
        tbl[8] = '{1, MODE_STOP,   0,  0,  0, 2'b11, 2'b00};
        tbl[9] = '{0, MODE_FWD,   14, 14,  0, 2'b11, 2'b00};
        for (int i = 0; i < 10; i++) begin
            send(tbl[i].ch, tbl[i].mode, tbl[i].duty);
            chk($sformatf("v%0d_err", i), int'(cmd_err), (tbl[i].ch >= 2) ? 1 : 0);
            sb.push_back(tbl[i]);
            repeat (200) @(negedge clk);
            win2(h0, h1);
            e = sb.pop_front();
            chk($sformatf("v%0d_hi0", i),   h0,          e.hi0);
            chk($sformatf("v%0d_hi1", i),   h1,          e.hi1);
            chk($sformatf("v%0d_dir", i),   int'(dir),   int'(e.dir));
            chk($sformatf("v%0d_brake", i), int'(brake), int'(e.brk));
        end

        // Reset asserted mid-ramp
        send(1, MODE_FWD, 12);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_pwm",   int'(pwm),       0);
        chk("midrst_brake", int'(brake),     0);
        chk("midrst_dir",   int'(dir),       3);
        chk("midrst_ready", int'(cmd_ready), 0);
        chk("midrst_err",   int'(cmd_err),   0);
        reset = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
